// File: rtl/mod_exp_pkg.sv
// Shared widths, FSM state encoding and the single interleaved
// modular-multiply step used by the multiplier datapath.
package mod_exp_pkg;

   localparam int BASE_W  = 8;
   localparam int EXP_W   = 8;
   localparam int MOD_W   = 16;
   localparam int OUT_W   = 8;
   localparam int RES_W   = MOD_W + 1;
   localparam int MUL_CYC = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      REDUCE = 3'd2,
      SQUARE = 3'd3,
      MULT   = 3'd4,
      WRITE  = 3'd5,
      DONE   = 3'd6
   } state_t;

   // One MSB-first step: r = 2r mod m, then r = (r + a) mod m when the
   // multiplier bit is set. Holding r < m and a < m keeps every
   // intermediate below 2m, which always fits in RES_W bits.
   function automatic logic [RES_W-1:0] mod_step(
      input logic [RES_W-1:0] r,
      input logic [MOD_W-1:0] a,
      input logic [MOD_W-1:0] m,
      input logic             bit_set
   );
      logic [RES_W-1:0] t;
      logic [RES_W-1:0] mm;
      mm = {1'b0, m};
      t  = {r[RES_W-2:0], 1'b0};
      if (t >= mm) t = t - mm;
      if (bit_set) begin
         t = t + {1'b0, a};
         if (t >= mm) t = t - mm;
      end
      return t;
   endfunction

endpackage

// File: rtl/mod_exp_unit_if.sv
// Operand/result bundle of the modular-exponentiation engine, plus
// debug visibility of the sequencer state and the multiplier activity.
interface mod_exp_unit_if;
   import mod_exp_pkg::*;

   // No handshake: the engine samples base/exp/modulus whenever it is in
   // DONE and recomputes on any change; result is valid whenever state is
   // DONE and otherwise holds the previous value.
   logic [BASE_W-1:0] base;
   logic [EXP_W-1:0]  exp;
   logic [MOD_W-1:0]  modulus;
   logic [OUT_W-1:0]  result;
   state_t            state;
   logic              mul_busy;

   modport master (
      output base, exp, modulus,
      input  result, state, mul_busy
   );

   modport slave (
      input  base, exp, modulus,
      output result, state, mul_busy
   );

endinterface

// File: rtl/mod_exp_unit_mod_mul.sv
// Sequential (a*b) mod m: one interleaved step per cycle over the 16
// multiplier bits, MSB first. The start edge performs the first step.
module mod_mul
   import mod_exp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [MOD_W-1:0] a,
   input  logic [MOD_W-1:0] b,
   input  logic [MOD_W-1:0] m,
   output logic             busy,
   output logic             done,
   output logic [MOD_W-1:0] r
);

   logic [MOD_W-1:0] r_a;
   logic [MOD_W-1:0] r_b;
   logic [MOD_W-1:0] r_m;
   logic [RES_W-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic             r_busy;
   logic             r_done;

   logic [MOD_W-1:0] w_a;
   logic [MOD_W-1:0] w_m;
   logic             w_bit;
   logic [RES_W-1:0] w_r_in;
   logic [RES_W-1:0] w_r_next;

   // Operands come straight from the ports on the start edge so the
   // caller can chain operations back-to-back without a gap cycle.
   always_comb begin
      w_a      = start ? a : r_a;
      w_m      = start ? m : r_m;
      w_bit    = start ? b[MOD_W-1] : r_b[4'd15 - r_cnt];
      w_r_in   = start ? '0 : r_acc;
      w_r_next = mod_step(w_r_in, w_a, w_m, w_bit);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_m    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_m    <= m;
            r_acc  <= w_r_next;
            r_cnt  <= 4'd1;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_acc <= w_r_next;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign r    = r_acc[MOD_W-1:0];

endmodule

// File: rtl/mod_exp_unit.sv
// Free-running left-to-right square-and-multiply engine computing
// (base ^ exp) mod modulus; recomputes whenever the operands change.
module mod_exp_unit
   import mod_exp_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   mod_exp_unit_if.slave  bus
);

   state_t            r_state;
   logic [BASE_W-1:0] r_base;
   logic [EXP_W-1:0]  r_exp;
   logic [MOD_W-1:0]  r_mod;
   logic [MOD_W-1:0]  r_acc;
   logic [MOD_W-1:0]  r_bb;
   logic [2:0]        r_idx;
   logic [OUT_W-1:0]  r_result;

   logic              w_start;
   logic [MOD_W-1:0]  w_a;
   logic [MOD_W-1:0]  w_b;
   logic [MOD_W-1:0]  w_m;
   logic [MOD_W-1:0]  w_acc_next;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [MOD_W-1:0]  w_mul_r;

   // w_acc_next is the accumulator value being committed this cycle; it is
   // forwarded into the next multiply so phases run back-to-back.
   always_comb begin
      w_acc_next = r_acc;
      w_start    = 1'b0;
      w_a        = '0;
      w_b        = '0;
      w_m        = r_mod;
      case (r_state)
         LOAD: begin
            w_start = 1'b1;
            w_a     = MOD_W'(1);
            w_b     = MOD_W'(bus.base);
            w_m     = bus.modulus;
         end
         REDUCE: begin
            w_start = w_mul_done;
            w_a     = r_acc;
            w_b     = r_acc;
         end
         SQUARE: begin
            if (w_mul_done) w_acc_next = w_mul_r;
            w_start = w_mul_done;
            w_a     = w_acc_next;
            w_b     = r_bb;
         end
         MULT: begin
            if (w_mul_done && r_exp[r_idx]) w_acc_next = w_mul_r;
            w_start = w_mul_done && (r_idx != 3'd0);
            w_a     = w_acc_next;
            w_b     = w_acc_next;
         end
         default: ;
      endcase
   end

   mod_mul u_mod_mul (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .a     (w_a),
      .b     (w_b),
      .m     (w_m),
      .busy  (w_mul_busy),
      .done  (w_mul_done),
      .r     (w_mul_r)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_base   <= '0;
         r_exp    <= '0;
         r_mod    <= '0;
         r_acc    <= '0;
         r_bb     <= '0;
         r_idx    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: r_state <= LOAD;
            LOAD: begin
               r_base  <= bus.base;
               r_exp   <= bus.exp;
               r_mod   <= bus.modulus;
               r_acc   <= MOD_W'(1);
               r_bb    <= '0;
               r_idx   <= 3'd7;
               r_state <= REDUCE;
            end
            REDUCE: begin
               if (w_mul_done) begin
                  r_bb    <= w_mul_r;
                  r_state <= SQUARE;
               end
            end
            SQUARE: begin
               if (w_mul_done) begin
                  r_acc   <= w_acc_next;
                  r_state <= MULT;
               end
            end
            MULT: begin
               if (w_mul_done) begin
                  r_acc <= w_acc_next;
                  if (r_idx == 3'd0) begin
                     r_state <= WRITE;
                  end else begin
                     r_idx   <= r_idx - 3'd1;
                     r_state <= SQUARE;
                  end
               end
            end
            WRITE: begin
               // Moduli 0 and 1 have no meaningful residue; report 0.
               r_result <= (r_mod <= MOD_W'(1)) ? '0 : r_acc[OUT_W-1:0];
               r_state  <= DONE;
            end
            DONE: begin
               if (bus.base != r_base || bus.exp != r_exp || bus.modulus != r_mod)
                  r_state <= LOAD;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.result   = r_result;
   assign bus.state    = r_state;
   assign bus.mul_busy = w_mul_busy;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Directed-vector bench for mod_exp_unit: RSA-style encrypt/decrypt,
// edge moduli/exponents, latency, result hold, and reset behaviour.
module tb_mod_exp_unit;
   import mod_exp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mod_exp_unit_if bus ();

   mod_exp_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [OUT_W-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_tests++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic wait_load(input string tag);
      int k;
      k = 0;
      while (bus.state != LOAD && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val({tag, "_load"}, 32'(bus.state), 32'(LOAD));
   endtask

   // Counts edges from entry into LOAD until DONE, checks the held result
   // never moves before DONE, then compares against the queued expectation.
   task automatic measure(input string tag, input int poke_cycle, input logic [7:0] poke_base);
      int n;
      int glitches;
      logic [OUT_W-1:0] held;
      logic [OUT_W-1:0] want;
      n        = 0;
      glitches = 0;
      wait_load(tag);
      held = bus.result;
      while (bus.state != DONE && n < 400) begin
         @(negedge clk);
         n++;
         if (n == poke_cycle) bus.base = poke_base;
         if (bus.state != DONE && bus.result !== held) glitches++;
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_val({tag, "_lat"}, 32'(n), 32'd274);
      check_val({tag, "_res"}, 32'(bus.result), 32'(want));
      check_val({tag, "_hold"}, 32'(glitches), 32'd0);
   endtask

   task automatic run_vec(input string tag, input logic [7:0] b, input logic [7:0] e,
                          input logic [15:0] m, input logic [7:0] want);
      bus.base    = b;
      bus.exp     = e;
      bus.modulus = m;
      exp_q.push_back(want);
      measure(tag, -1, 8'd0);
   endtask

   initial begin
      bus.base    = 8'd5;
      bus.exp     = 8'd7;
      bus.modulus = 16'd143;
      rst         = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_res", 32'(bus.result), 32'd0);
      check_val("rst_state", 32'(bus.state), 32'(IDLE));
      rst = 1'b1;

      exp_q.push_back(8'd47);
      measure("enc5", -1, 8'd0);
      run_vec("enc3",   8'd3,   8'd7,   16'd143,  8'd42);
      run_vec("enc2",   8'd2,   8'd7,   16'd143,  8'd128);
      run_vec("dec42",  8'd42,  8'd103, 16'd143,  8'd3);
      run_vec("dec47",  8'd47,  8'd103, 16'd143,  8'd5);
      run_vec("exp0",   8'd5,   8'd0,   16'd143,  8'd1);
      run_vec("mod1",   8'd5,   8'd7,   16'd1,    8'd0);
      run_vec("mod0",   8'd5,   8'd7,   16'd0,    8'd0);
      run_vec("bigb",   8'd200, 8'd1,   16'd143,  8'd57);
      run_vec("wide",   8'd200, 8'd2,   16'd1009, 8'd137);

      // Abort a computation with reset while result still shows 137.
      bus.base    = 8'd5;
      bus.exp     = 8'd7;
      bus.modulus = 16'd143;
      wait_load("rst_mid");
      repeat (60) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst_mid_res", 32'(bus.result), 32'd0);
      check_val("rst_mid_state", 32'(bus.state), 32'(IDLE));
      repeat (3) @(negedge clk);
      check_val("rst_hold_res", 32'(bus.result), 32'd0);
      rst = 1'b1;
      exp_q.push_back(8'd47);
      measure("after_rst", -1, 8'd0);

      run_vec("enc2b", 8'd2, 8'd7, 16'd143, 8'd128);

      // Change base mid-computation: old operands finish, then new ones run.
      bus.base = 8'd5;
      exp_q.push_back(8'd47);
      exp_q.push_back(8'd42);
      measure("busy_first", 100, 8'd3);
      measure("busy_second", -1, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
